// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op decode for the iterative mul/div unit.
// Defining MULDIV_SDIV_EN makes OP_SDIV (signed truncating divide) a supported op.
package muldiv_pkg;

  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_SMUL = 4'b0110;
  localparam logic [3:0] OP_UMUL = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_SDIV = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      OP_MUL, OP_SMUL, OP_UMUL, OP_DIV: return 1'b1;
`ifdef MULDIV_SDIV_EN
      OP_SDIV: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_SDIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with final sign fix-up.
// acc holds {hi,lo}: product accumulator for multiply, {remainder,quotient} for divide.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, opb;
  logic [2*WIDTH-1:0] acc, acc_nx, acc_neg;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_diff, lo_neg, hi_neg;
  logic               is_div, neg_all, neg_lo, neg_hi, hi_zero;

  always_comb begin
    signed_op = (op == OP_SMUL) || (op == OP_SDIV);
    a_neg     = signed_op && a[WIDTH-1];
    b_neg     = signed_op && b[WIDTH-1];
    a_mag     = a_neg ? ('0 - a) : a;
    b_mag     = b_neg ? ('0 - b) : b;
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    // When rem_sh >= opb the difference is below opb, so WIDTH bits suffice
    rem_diff = rem_sh[WIDTH-1:0] - opb;
    acc_nx   = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (rem_sh >= {1'b0, opb}) acc_nx = {rem_diff, acc[WIDTH-2:0], 1'b1};
      else                       acc_nx = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    acc_neg = '0 - acc;
    lo_neg  = '0 - acc[WIDTH-1:0];
    hi_neg  = '0 - acc[2*WIDTH-1:WIDTH];
    res_lo  = neg_all ? acc_neg[WIDTH-1:0] : (neg_lo ? lo_neg : acc[WIDTH-1:0]);
    res_hi  = hi_zero ? '0 :
              neg_all ? acc_neg[2*WIDTH-1:WIDTH] :
              neg_hi  ? hi_neg : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_all <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      hi_zero <= 1'b0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, a_mag};
      opb     <= b_mag;
      is_div  <= op_is_div(op);
      neg_all <= (op == OP_SMUL) && (a_neg ^ b_neg);
      neg_lo  <= (op == OP_SDIV) && (a_neg ^ b_neg);
      neg_hi  <= (op == OP_SDIV) && a_neg;
      hi_zero <= (op == OP_MUL);
    end else if (step) begin
      acc <= acc_nx;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/SMUL/UMUL/DIV unit: control FSM, iteration counter, handshake and result registers.
// SDIV support follows the MULDIV_SDIV_EN build option (see muldiv_pkg).
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       ALUFlags
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic             accept, div0, div0_q;
  logic             dp_load, dp_step, res_we;
  logic [WIDTH-1:0] a_q, dp_lo, dp_hi, res_lo_nx, res_hi_nx;

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (dp_load),
    .step   (dp_step),
    .op     (op),
    .a      (a),
    .b      (b),
    .res_lo (dp_lo),
    .res_hi (dp_hi)
  );

  always_comb begin
    busy   = (state == RUN) || (state == FIX);
    done   = (state == DONE);
    accept = start && !busy && op_supported(op);
    div0   = op_is_div(op) && (b == '0);
  end

  // Divide-by-zero skips RUN and spends its single busy cycle in FIX
  always_comb begin
    state_nx = state;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    res_we   = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (accept) begin
          state_nx = div0 ? FIX : RUN;
          dp_load  = !div0;
        end
      end
      RUN: begin
        dp_step = 1'b1;
        if (count == '0) state_nx = FIX;
      end
      FIX: begin
        res_we   = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
    res_lo_nx = div0_q ? '1  : dp_lo;
    res_hi_nx = div0_q ? a_q : dp_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      div0_q   <= 1'b0;
      a_q      <= '0;
      Result   <= '0;
      ResultHi <= '0;
      ALUFlags <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        div0_q <= div0;
        a_q    <= a;
        count  <= CW'(WIDTH - 1);
      end else if (dp_step) begin
        count <= count - 1'b1;
      end
      if (res_we) begin
        Result   <= res_lo_nx;
        ResultHi <= res_hi_nx;
        ALUFlags <= {res_lo_nx[WIDTH-1], (res_lo_nx == '0), 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam logic [3:0] T_MUL  = 4'b0111;
  localparam logic [3:0] T_SMUL = 4'b0110;
  localparam logic [3:0] T_UMUL = 4'b0101;
  localparam logic [3:0] T_DIV  = 4'b0100;
  localparam logic [3:0] T_SDIV = 4'b1110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] Result, ResultHi;
  logic [3:0]  ALUFlags;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_hi = '0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .Result   (Result),
    .ResultHi (ResultHi),
    .ALUFlags (ALUFlags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic is_div(input logic [3:0] o);
    return (o == T_DIV) || (o == T_SDIV);
  endfunction

  // Returns {hi, lo}
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] lo32;
    longint sx, sy, q, r, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      T_MUL:  begin lo32 = x * y; return {32'h0, lo32}; end
      T_UMUL: return {32'h0, x} * {32'h0, y};
      T_SMUL: begin p = sx * sy; return p; end
      T_DIV:  return (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      T_SDIV: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    logic [63:0] e;
    int n, lat;
    e   = model(o, x, y);
    lat = (is_div(o) && y == 0) ? 2 : 34;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) check("busy_after_start", {63'h0, busy}, 64'h1);
      start = (n == poke) && !done;
      if (start) op = T_UMUL;
    end while (!done && n < 100);
    start = 1'b0;
    check("latency", n, lat);
    check("busy_at_done", {63'h0, busy}, 64'h0);
    check("result_lo", {32'h0, Result}, {32'h0, e[31:0]});
    check("result_hi", {32'h0, ResultHi}, {32'h0, e[63:32]});
    check("flags", {60'h0, ALUFlags}, {60'h0, e[31], (e[31:0] == 32'h0), 2'b00});
    exp_lo = e[31:0];
    exp_hi = e[63:32];
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("done_one_cycle", {63'h0, done}, 64'h0);
    check("busy_idle", {63'h0, busy}, 64'h0);
    check("hold_lo", {32'h0, Result}, {32'h0, exp_lo});
    check("hold_hi", {32'h0, ResultHi}, {32'h0, exp_hi});
  endtask

  task automatic unsupported(input logic [3:0] o);
    start = 1'b1; op = o; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    check("unsup_busy", {63'h0, busy}, 64'h0);
    check("unsup_done", {63'h0, done}, 64'h0);
    check("unsup_hold", {ResultHi, Result}, {exp_hi, exp_lo});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corner [4];
    corner[0] = 32'h8000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h0; corner[3] = 32'h1;
    case ($urandom_range(0, 3))
      0:       return corner[$urandom_range(0, 3)];
      1:       return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [5];
    int nops, d0;
    ops[0] = T_MUL; ops[1] = T_SMUL; ops[2] = T_UMUL; ops[3] = T_DIV; ops[4] = T_SDIV;
`ifdef MULDIV_SDIV_EN
    nops = 5;
`else
    nops = 4;
`endif

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_result", {ResultHi, Result}, 64'h0);
    check("rst_flags", {60'h0, ALUFlags}, 64'h0);

    do_op(T_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("umul_max_hi", {32'h0, ResultHi}, 64'hFFFF_FFFE);
    idle_check();
    do_op(T_SMUL, 32'hFFFF_FFFD, 32'd5, 0);
    check("smul_neg_n", {63'h0, ALUFlags[3]}, 64'h1);
    idle_check();
    do_op(T_DIV, 32'd100, 32'd7, 0);
    do_op(T_DIV, 32'd5, 32'd0, 0);
    idle_check();

    d0 = done_cnt;
    do_op(T_MUL, 32'h0001_0000, 32'h0001_0000, 4);
    check("mul_zero_z", {63'h0, ALUFlags[2]}, 64'h1);
    repeat (40) @(negedge clk);
    check("single_done", done_cnt - d0, 1);

    unsupported(4'b0000);
`ifndef MULDIV_SDIV_EN
    unsupported(T_SDIV);
`endif

    // Abort a UMUL with reset sampled at the tenth edge after acceptance
    d0 = done_cnt;
    start = 1'b1; op = T_UMUL; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_abort", {63'h0, busy}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    exp_lo = '0; exp_hi = '0;
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_result", {ResultHi, Result}, 64'h0);
    do_op(T_DIV, 32'd9, 32'd3, 0);
    idle_check();

`ifdef MULDIV_SDIV_EN
    do_op(T_SDIV, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(T_SDIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(T_SDIV, 32'hFFFF_FF00, 32'd0, 0);
    idle_check();
`endif

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  o;
      logic [31:0] x, y;
      o = ops[$urandom_range(0, nops - 1)];
      x = pick_operand();
      y = ($urandom_range(0, 7) == 0) ? 32'h0 : pick_operand();
      do_op(o, x, y, 0);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
